// File: rtl/alu_driver_pkg.sv
// Shared types for the ALU driver: FSM states, ALU function codes
// and the bit layout of one log entry.
package alu_driver_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRIVE,
      S_SETTLE,
      S_CAPTURE,
      S_FINISH
   } state_e;

   typedef enum logic [2:0] {
      FN_ADD = 3'd0,
      FN_SUB = 3'd1,
      FN_NOT = 3'd2,
      FN_AND = 3'd3,
      FN_OR  = 3'd4,
      FN_XOR = 3'd5,
      FN_CMP = 3'd6,
      FN_EQ  = 3'd7
   } func_e;

   localparam int LOG_W     = 8;
   localparam int LOG_DEPTH = 8;
   localparam int LOG_RES   = 4;
   localparam int LOG_ZERO  = 3;
   localparam int LOG_OVF   = 2;
   localparam int LOG_CARRY = 1;
   localparam int LOG_OUT   = 0;

   function automatic logic [LOG_W-1:0] pack_entry(
      input logic [3:0] res,
      input logic       zero,
      input logic       ovf,
      input logic       carry,
      input logic       out
   );
      logic [LOG_W-1:0] e;
      e = '0;
      e[LOG_RES +: 4] = res;
      e[LOG_ZERO]     = zero;
      e[LOG_OVF]      = ovf;
      e[LOG_CARRY]    = carry;
      e[LOG_OUT]      = out;
      return e;
   endfunction

endpackage

// File: rtl/alu_driver_debounce.sv
// Two-flop synchroniser plus stability-counter debouncer with a
// registered rising-edge pulse on the debounced level.
module btn_debounce #(
   parameter int DB_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic rise
);

   localparam int CW = $clog2(DB_CYCLES + 1);

   logic [1:0]    sync_q;
   logic [CW-1:0] cnt_q;
   logic          level_q;
   logic          rise_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], raw};
         rise_q <= 1'b0;
         if (sync_q[1] == level_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
            cnt_q   <= '0;
            level_q <= sync_q[1];
            rise_q  <= sync_q[1];
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign level = level_q;
   assign rise  = rise_q;

endmodule

// File: rtl/alu_driver.sv
// Button-triggered driver for an external 4-bit ALU: applies one
// operation or sweeps all eight, logging each response by func code.
module alu_driver
   import alu_driver_pkg::*;
#(
   parameter int DB_CYCLES = 16,
   parameter int SETTLE    = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn,
   input  logic       auto_en,
   input  logic [2:0] sw_func,
   input  logic [3:0] sw_a,
   input  logic [3:0] sw_b,
   output logic [2:0] alu_func,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   input  logic [3:0] alu_result,
   input  logic       alu_zero,
   input  logic       alu_overflow,
   input  logic       alu_carry,
   input  logic       alu_out,
   input  logic [2:0] log_idx,
   output logic [7:0] log_data,
   output logic       busy,
   output logic       done
);

   state_e           state_q;
   logic [3:0]       set_cnt_q;
   logic [2:0]       step_q;
   logic             sweep_q;
   logic [2:0]       op_func_q;
   logic [3:0]       op_a_q;
   logic [3:0]       op_b_q;
   logic [2:0]       alu_func_q;
   logic [3:0]       alu_a_q;
   logic [3:0]       alu_b_q;
   logic             busy_q;
   logic             done_q;
   logic [LOG_W-1:0] log_q [LOG_DEPTH];

   logic db_level;
   logic db_rise;

   btn_debounce #(
      .DB_CYCLES(DB_CYCLES)
   ) u_db (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (btn),
      .level(db_level),
      .rise (db_rise)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         set_cnt_q  <= '0;
         step_q     <= '0;
         sweep_q    <= 1'b0;
         op_func_q  <= '0;
         op_a_q     <= '0;
         op_b_q     <= '0;
         alu_func_q <= '0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         for (int i = 0; i < LOG_DEPTH; i++) log_q[i] <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (db_rise) begin
                  op_func_q <= sw_func;
                  op_a_q    <= sw_a;
                  op_b_q    <= sw_b;
                  sweep_q   <= auto_en;
                  step_q    <= '0;
                  busy_q    <= 1'b1;
                  state_q   <= S_DRIVE;
               end
            end
            S_DRIVE: begin
               alu_func_q <= sweep_q ? step_q : op_func_q;
               alu_a_q    <= op_a_q;
               alu_b_q    <= op_b_q;
               set_cnt_q  <= '0;
               state_q    <= S_SETTLE;
            end
            S_SETTLE: begin
               if (set_cnt_q == 4'(SETTLE - 1)) state_q <= S_CAPTURE;
               else set_cnt_q <= set_cnt_q + 1'b1;
            end
            S_CAPTURE: begin
               log_q[alu_func_q] <= pack_entry(alu_result, alu_zero,
                                               alu_overflow, alu_carry,
                                               alu_out);
               // step stops at the last func code instead of wrapping
               if (sweep_q && step_q != 3'(FN_EQ)) begin
                  step_q  <= step_q + 1'b1;
                  state_q <= S_DRIVE;
               end else begin
                  done_q  <= 1'b1;
                  state_q <= S_FINISH;
               end
            end
            S_FINISH: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign alu_func = alu_func_q;
   assign alu_a    = alu_a_q;
   assign alu_b    = alu_b_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign log_data = log_q[log_idx];

endmodule

// File: tb/tb_alu_driver.sv
// Directed bench for alu_driver with a behavioural 4-bit ALU attached.
module tb_alu_driver;

   localparam int DB = 16;
   localparam int ST = 5;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       btn;
   logic       auto_en;
   logic [2:0] sw_func;
   logic [3:0] sw_a;
   logic [3:0] sw_b;
   logic [2:0] alu_func;
   logic [3:0] alu_a;
   logic [3:0] alu_b;
   logic [3:0] m_res;
   logic       m_z;
   logic       m_v;
   logic       m_c;
   logic       m_o;
   logic [4:0] m_s;
   logic [2:0] log_idx;
   logic [7:0] log_data;
   logic       busy;
   logic       done;

   int n_chk = 0;
   int n_fail = 0;
   int done_cnt = 0;
   int busy_rises = 0;
   int cyc = 0;
   int done_lat = 0;
   logic busy_p = 1'b0;

   logic [7:0] sweep_exp [8];

   always #5 clk = ~clk;

   alu_driver #(
      .DB_CYCLES(DB),
      .SETTLE   (ST)
   ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn         (btn),
      .auto_en     (auto_en),
      .sw_func     (sw_func),
      .sw_a        (sw_a),
      .sw_b        (sw_b),
      .alu_func    (alu_func),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_result  (m_res),
      .alu_zero    (m_z),
      .alu_overflow(m_v),
      .alu_carry   (m_c),
      .alu_out     (m_o),
      .log_idx     (log_idx),
      .log_data    (log_data),
      .busy        (busy),
      .done        (done)
   );

   // reference ALU: CMP/EQ report on out with a zero result
   always_comb begin
      m_s   = '0;
      m_res = '0;
      m_v   = 1'b0;
      m_c   = 1'b0;
      m_o   = 1'b0;
      case (alu_func)
         3'd0: begin
            m_s   = {1'b0, alu_a} + {1'b0, alu_b};
            m_res = m_s[3:0];
            m_c   = m_s[4];
            m_v   = (alu_a[3] == alu_b[3]) && (m_s[3] != alu_a[3]);
         end
         3'd1: begin
            m_s   = {1'b0, alu_a} - {1'b0, alu_b};
            m_res = m_s[3:0];
            m_c   = m_s[4];
            m_v   = (alu_a[3] != alu_b[3]) && (m_s[3] != alu_a[3]);
         end
         3'd2: m_res = ~alu_a;
         3'd3: m_res = alu_a & alu_b;
         3'd4: m_res = alu_a | alu_b;
         3'd5: m_res = alu_a ^ alu_b;
         3'd6: m_o = (alu_a < alu_b);
         default: m_o = (alu_a == alu_b);
      endcase
      m_z = (m_res == 4'd0);
   end

   always @(negedge clk) begin
      if (busy && !busy_p) begin
         busy_rises++;
         cyc = 1;
      end else if (busy) begin
         cyc++;
      end
      if (done) begin
         done_cnt++;
         done_lat = cyc;
      end
      busy_p = busy;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clocks(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic wait_done(input int d0, input int maxc);
      int k;
      k = 0;
      while (done_cnt == d0 && k < maxc) begin
         clocks(1);
         k++;
      end
   endtask

   task automatic wait_busy(input int maxc, output int n);
      n = 0;
      while (!busy && n < maxc) begin
         clocks(1);
         n++;
      end
   endtask

   initial begin
      int d0;
      int r0;
      int n;
      sweep_exp = '{8'h60, 8'h08, 8'hC0, 8'h30,
                    8'h30, 8'h08, 8'h08, 8'h09};
      rst_n   = 1'b0;
      btn     = 1'b0;
      auto_en = 1'b0;
      sw_func = 3'd0;
      sw_a    = 4'd0;
      sw_b    = 4'd0;
      log_idx = 3'd0;
      clocks(3);
      chk("rst_func", 32'(alu_func), 32'd0);
      chk("rst_a", 32'(alu_a), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_log0", 32'(log_data), 32'd0);
      rst_n = 1'b1;
      clocks(2);

      // single ADD 7+1
      sw_func = 3'd0;
      sw_a    = 4'd7;
      sw_b    = 4'd1;
      d0      = done_cnt;
      btn     = 1'b1;
      wait_done(d0, 200);
      chk("add_done_cnt", 32'(done_cnt), 32'(d0 + 1));
      chk("add_latency", 32'(done_lat), 32'(ST + 3));
      log_idx = 3'd0;
      #1;
      chk("add_log0", 32'(log_data), 32'h84);
      log_idx = 3'd1;
      #1;
      chk("add_log1_untouched", 32'(log_data), 32'h00);
      chk("add_alu_a_held", 32'(alu_a), 32'd7);
      btn = 1'b0;
      clocks(DB + 4);
      chk("add_idle", 32'(busy), 32'd0);

      // single SUB 5-2, switches wiggle during SETTLE
      sw_func = 3'd1;
      sw_a    = 4'd5;
      sw_b    = 4'd2;
      d0      = done_cnt;
      btn     = 1'b1;
      wait_busy(100, n);
      clocks(2);
      sw_func = 3'd3;
      sw_a    = 4'hF;
      sw_b    = 4'h0;
      clocks(1);
      chk("settle_alu_a", 32'(alu_a), 32'd5);
      chk("settle_alu_b", 32'(alu_b), 32'd2);
      chk("settle_alu_func", 32'(alu_func), 32'd1);
      wait_done(d0, 200);
      log_idx = 3'd1;
      #1;
      chk("sub_log1", 32'(log_data), 32'h30);
      log_idx = 3'd3;
      #1;
      chk("sub_log3_untouched", 32'(log_data), 32'h00);
      btn = 1'b0;
      clocks(DB + 4);

      // sweep 3,3 with a second press while busy
      auto_en = 1'b1;
      sw_func = 3'd6;
      sw_a    = 4'd3;
      sw_b    = 4'd3;
      d0      = done_cnt;
      r0      = busy_rises;
      btn     = 1'b1;
      wait_busy(100, n);
      btn = 1'b0;
      clocks(22);
      btn = 1'b1;
      wait_done(d0, 400);
      chk("sweep_latency", 32'(done_lat), 32'(8 * (ST + 2) + 1));
      clocks(40);
      chk("sweep_one_done", 32'(done_cnt), 32'(d0 + 1));
      chk("sweep_no_restart", 32'(busy_rises), 32'(r0 + 1));
      chk("sweep_idle", 32'(busy), 32'd0);
      for (int i = 0; i < 8; i++) begin
         log_idx = 3'(i);
         #1;
         chk($sformatf("sweep_log%0d", i), 32'(log_data),
             32'(sweep_exp[i]));
      end
      btn = 1'b0;
      clocks(DB + 4);

      // bouncing button, then steady high
      auto_en = 1'b0;
      r0      = busy_rises;
      for (int i = 0; i < 20; i++) begin
         btn = ~btn;
         clocks(5);
      end
      chk("bounce_no_trigger", 32'(busy_rises), 32'(r0));
      d0  = done_cnt;
      btn = 1'b1;
      wait_busy(100, n);
      // 2 sync + DB stable cycles, then one cycle for IDLE->DRIVE
      chk("bounce_trigger_delay", 32'(n), 32'(DB + 3));
      wait_done(d0, 200);
      chk("bounce_one_trigger", 32'(busy_rises), 32'(r0 + 1));
      btn = 1'b0;
      clocks(DB + 4);

      // reset at sweep step 4
      auto_en = 1'b1;
      sw_a    = 4'd3;
      sw_b    = 4'd3;
      d0      = done_cnt;
      btn     = 1'b1;
      n       = 0;
      while (!(busy && alu_func == 3'd4) && n < 300) begin
         clocks(1);
         n++;
      end
      chk("reached_step4", 32'(alu_func), 32'd4);
      rst_n = 1'b0;
      #1;
      chk("abort_func", 32'(alu_func), 32'd0);
      chk("abort_a", 32'(alu_a), 32'd0);
      chk("abort_b", 32'(alu_b), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      for (int i = 0; i < 8; i++) begin
         log_idx = 3'(i);
         #1;
         chk($sformatf("abort_log%0d", i), 32'(log_data), 32'd0);
      end
      clocks(10);
      rst_n = 1'b1;
      wait_busy(100, n);
      chk("abort_no_done", 32'(done_cnt), 32'(d0));
      chk("post_rst_trigger_delay", 32'(n), 32'(DB + 3));
      wait_done(d0, 400);
      chk("post_rst_done", 32'(done_cnt), 32'(d0 + 1));

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
